// File: rtl/dbus_arbiter_pkg.sv
// Shared bus types for the data-bus arbiter: master ids, arbiter states and
// the request bundle that the core and the loader both produce.
package dbus_arbiter_pkg;

  localparam int BUS_ADDR_W = 32;
  localparam int BUS_DATA_W = 32;

  typedef enum logic {
    MST_CORE = 1'b0,
    MST_DMA  = 1'b1
  } mst_e;

  typedef enum logic {
    ARB  = 1'b0,
    LOCK = 1'b1
  } arb_state_e;

  typedef struct packed {
    logic                  we;
    logic [BUS_ADDR_W-1:0] addr;
    logic [BUS_DATA_W-1:0] wdata;
  } bus_req_t;

endpackage

// File: rtl/dbus_arbiter_if.sv
// One master's port onto the shared data bus: request, write data and the
// grant / read-return handshake coming back from the arbiter.
interface dbus_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              gnt;
  logic              rvalid;
  logic [DATA_W-1:0] rdata;

  modport master (
    output req, we, addr, wdata,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, we, addr, wdata,
    output gnt, rvalid, rdata
  );

endinterface

// File: rtl/dbus_arbiter_rr_pick2.sv
// Combinational two-way round-robin pick: a lone requester always wins,
// a conflict goes to the master that was not granted most recently.
module dbus_arbiter_rr_pick2
  import dbus_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  mst_e       last,
  output logic [1:0] gnt
);

  // Resolve the conflict case against the most recent winner
  always_comb begin
    gnt = req;
    if (req == 2'b11) begin
      gnt = (last == MST_DMA) ? 2'b01 : 2'b10;
    end
  end

endmodule

// File: rtl/dbus_arbiter.sv
// Data-bus arbiter sharing the single-port data RAM between the core (M0)
// and the DMA/loader (M1). Same-cycle grant, registered read return, and
// optional M1 locked bursts capped at MAX_BURST beats.
module dbus_arbiter
  import dbus_arbiter_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MAX_BURST = 8
) (
  input  logic              clk,
  input  logic              reset,
  dbus_arbiter_if.slave     m0,
  dbus_arbiter_if.slave     m1,
  input  logic              m1_lock,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  localparam int               CNT_W   = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BURST);

  arb_state_e       state, state_n;
  mst_e             last, last_n;
  logic [CNT_W-1:0] beat_cnt, beat_n;
  logic [1:0]       pick;
  logic             gnt0, gnt1;
  logic             rvalid0, rvalid1;
  logic [DATA_W-1:0] rdata0, rdata1;

  dbus_arbiter_rr_pick2 u_pick (
    .req  ({m1.req, m0.req}),
    .last (last),
    .gnt  (pick)
  );

  // Next state, burst bookkeeping and the grants; nothing is granted in reset
  always_comb begin
    gnt0    = 1'b0;
    gnt1    = 1'b0;
    state_n = state;
    last_n  = last;
    beat_n  = beat_cnt;
    if (reset) begin
      unique case (state)
        ARB: begin
          gnt0 = pick[0];
          gnt1 = pick[1];
          if (pick[1] && m1_lock) begin
            state_n = LOCK;
            beat_n  = CNT_W'(1);
          end
        end
        LOCK: begin
          if (!m1_lock || beat_cnt >= MAX_CNT) begin
            // M1 gives up the bus; M0 may take it in the same cycle
            state_n = ARB;
            beat_n  = '0;
            last_n  = MST_DMA;
            gnt0    = m0.req;
          end else if (m1.req) begin
            gnt1   = 1'b1;
            beat_n = beat_cnt + CNT_W'(1);
          end
        end
      endcase
      if (gnt0) begin
        last_n = MST_CORE;
      end else if (gnt1) begin
        last_n = MST_DMA;
      end
    end
  end

  // Arbiter state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= ARB;
      last     <= MST_DMA;
      beat_cnt <= '0;
    end else begin
      state    <= state_n;
      last     <= last_n;
      beat_cnt <= beat_n;
    end
  end

  // RAM port follows whichever master holds the grant, quiet otherwise
  always_comb begin
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    if (gnt0) begin
      ram_we    = m0.we;
      ram_addr  = m0.addr;
      ram_wdata = m0.wdata;
    end else if (gnt1) begin
      ram_we    = m1.we;
      ram_addr  = m1.addr;
      ram_wdata = m1.wdata;
    end
  end

  // Read return: capture RAM data at the read-grant edge, valid for one cycle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
      rdata0  <= '0;
      rdata1  <= '0;
    end else begin
      rvalid0 <= gnt0 & ~m0.we;
      rvalid1 <= gnt1 & ~m1.we;
      if (gnt0 && !m0.we) begin
        rdata0 <= ram_rdata;
      end
      if (gnt1 && !m1.we) begin
        rdata1 <= ram_rdata;
      end
    end
  end

  assign m0.gnt    = gnt0;
  assign m1.gnt    = gnt1;
  assign m0.rvalid = rvalid0;
  assign m1.rvalid = rvalid1;
  assign m0.rdata  = rdata0;
  assign m1.rdata  = rdata1;

endmodule

// File: tb/tb_dbus_arbiter.sv
// Bench for dbus_arbiter: directed scenarios plus a randomized run checked
// against a rule-level model of the arbitration and a shadow memory.
module tb_dbus_arbiter;

  localparam int MAXB = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        m1_lock;
  logic        ram_we;
  logic [31:0] ram_addr, ram_wdata, ram_rdata;
  logic [31:0] ram_mem [256];
  logic [31:0] exp_mem [256];

  dbus_arbiter_if #(.ADDR_W(32), .DATA_W(32)) m0_if ();
  dbus_arbiter_if #(.ADDR_W(32), .DATA_W(32)) m1_if ();

  dbus_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_BURST(MAXB)) dut (
    .clk       (clk),
    .reset     (rst_n),
    .m0        (m0_if),
    .m1        (m1_if),
    .m1_lock   (m1_lock),
    .ram_we    (ram_we),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata)
  );

  always #5 clk = ~clk;

  // Environment RAM: combinational read, write at the clock edge
  assign ram_rdata = ram_mem[ram_addr[9:2]];
  always @(posedge clk) if (ram_we) ram_mem[ram_addr[9:2]] <= ram_wdata;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  bit          mdl_locked;
  int          mdl_beats;
  int          mdl_last;
  bit          e_g0, e_g1, e_we, e_rv0, e_rv1;
  logic [31:0] e_addr, e_wdata, e_rd0, e_rd1;
  logic        c_w0, c_w1;
  logic [31:0] c_a0, c_a1, c_d0, c_d1;

  task automatic model_reset();
    mdl_locked = 0; mdl_beats = 0; mdl_last = 1;
    e_g0 = 0; e_g1 = 0; e_rv0 = 0; e_rv1 = 0; e_rd0 = '0; e_rd1 = '0;
  endtask

  // Apply one cycle of inputs and predict grants / RAM port for it
  task automatic drive(input logic r0, input logic w0, input logic [31:0] a0,
                       input logic [31:0] d0, input logic r1, input logic l1,
                       input logic w1, input logic [31:0] a1, input logic [31:0] d1);
    m0_if.req = r0; m0_if.we = w0; m0_if.addr = a0; m0_if.wdata = d0;
    m1_if.req = r1; m1_if.we = w1; m1_if.addr = a1; m1_if.wdata = d1;
    m1_lock = l1;
    c_w0 = w0; c_a0 = a0; c_d0 = d0; c_w1 = w1; c_a1 = a1; c_d1 = d1;
    e_g0 = 0; e_g1 = 0;
    if (mdl_locked) begin
      if (mdl_beats >= MAXB || !l1) begin
        mdl_locked = 0; mdl_beats = 0; mdl_last = 1;
        e_g0 = r0;
      end else if (r1) begin
        e_g1 = 1; mdl_beats = mdl_beats + 1;
      end
    end else begin
      if (r0 && r1) begin
        if (mdl_last == 1) e_g0 = 1; else e_g1 = 1;
      end else begin
        e_g0 = r0; e_g1 = r1;
      end
      if (e_g1 && l1) begin mdl_locked = 1; mdl_beats = 1; end
    end
    if (e_g0) mdl_last = 0;
    if (e_g1) mdl_last = 1;
    e_we    = (e_g0 && w0) || (e_g1 && w1);
    e_addr  = e_g0 ? a0 : (e_g1 ? a1 : 32'h0);
    e_wdata = e_g0 ? d0 : (e_g1 ? d1 : 32'h0);
    #2;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Advance one clock and update the shadow memory / read-return prediction
  task automatic tick();
    @(posedge clk);
    e_rv0 = e_g0 && !c_w0;
    e_rv1 = e_g1 && !c_w1;
    if (e_rv0) e_rd0 = exp_mem[c_a0[9:2]];
    if (e_rv1) e_rd1 = exp_mem[c_a1[9:2]];
    if (e_g0 && c_w0) exp_mem[c_a0[9:2]] = c_d0;
    if (e_g1 && c_w1) exp_mem[c_a1[9:2]] = c_d1;
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #3;
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(1, 1, 32'h10, 32'h55, 1, 1, 1, 32'h14, 32'h66);
    model_reset();
    n_tests++; if (m0_if.gnt !== 1'b0 || m1_if.gnt !== 1'b0) begin
      n_fail++; $display("FAIL rst_gnt: got %b%b want 00", m0_if.gnt, m1_if.gnt); end
    n_tests++; if (ram_we !== 1'b0 || ram_addr !== 32'h0 || ram_wdata !== 32'h0) begin
      n_fail++; $display("FAIL rst_ram: we=%b addr=%h wdata=%h want 0", ram_we, ram_addr, ram_wdata); end
    n_tests++; if (m0_if.rvalid !== 1'b0 || m1_if.rvalid !== 1'b0 ||
                   m0_if.rdata !== 32'h0 || m1_if.rdata !== 32'h0) begin
      n_fail++; $display("FAIL rst_rd: rv=%b%b rd0=%h rd1=%h want 0", m0_if.rvalid,
                         m1_if.rvalid, m0_if.rdata, m1_if.rdata); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle();
  endtask

  task automatic test_write_read();
    drive(1, 1, 32'h100, 32'hDEADBEEF, 0, 0, 0, 0, 0);
    n_tests++; if (m0_if.gnt !== 1'b1 || ram_we !== 1'b1 || ram_addr !== 32'h100 ||
                   ram_wdata !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL wr_gnt: gnt=%b we=%b addr=%h wdata=%h want 1 1 100 deadbeef",
                         m0_if.gnt, ram_we, ram_addr, ram_wdata); end
    tick();
    n_tests++; if (m0_if.rvalid !== 1'b0) begin
      n_fail++; $display("FAIL wr_rvalid: got %b want 0", m0_if.rvalid); end
    drive(1, 0, 32'h100, 0, 0, 0, 0, 0, 0);
    n_tests++; if (m0_if.gnt !== 1'b1 || ram_we !== 1'b0) begin
      n_fail++; $display("FAIL rd_gnt: gnt=%b we=%b want 1 0", m0_if.gnt, ram_we); end
    tick();
    idle();
    n_tests++; if (m0_if.rvalid !== 1'b1 || m0_if.rdata !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL rd_data: rvalid=%b rdata=%h want 1 deadbeef",
                         m0_if.rvalid, m0_if.rdata); end
    tick();
  endtask

  task automatic test_round_robin();
    do_reset();
    for (int i = 0; i < 6; i++) begin
      drive(1, 0, 32'(i * 4), 0, 1, 0, 0, 32'(i * 4 + 32'h200), 0);
      n_tests++; if (m0_if.gnt !== ((i % 2) == 0) || m1_if.gnt !== ((i % 2) == 1)) begin
        n_fail++; $display("FAIL rr_seq[%0d]: got %b%b want %b%b", i, m0_if.gnt,
                           m1_if.gnt, ((i % 2) == 0), ((i % 2) == 1)); end
      tick();
    end
    idle(); tick();
  endtask

  task automatic test_lock_burst();
    int run, max_run, n1, n0;
    run = 0; max_run = 0; n1 = 0; n0 = 0;
    for (int i = 0; i < 12; i++) begin
      drive(1, 0, 32'h40, 0, 1, 1, 0, 32'h80, 0);
      n_tests++; if (m0_if.gnt !== e_g0 || m1_if.gnt !== e_g1) begin
        n_fail++; $display("FAIL burst[%0d]: got %b%b want %b%b", i, m0_if.gnt,
                           m1_if.gnt, e_g0, e_g1); end
      if (m1_if.gnt === 1'b1) begin n1++; run++; if (run > max_run) max_run = run; end
      else run = 0;
      if (m0_if.gnt === 1'b1) n0++;
      tick();
    end
    n_tests++; if (max_run != MAXB || n0 == 0 || n1 <= MAXB) begin
      n_fail++; $display("FAIL burst_cap: max_run=%0d m0=%0d m1=%0d want run %0d",
                         max_run, n0, n1, MAXB); end
    idle(); tick();
  endtask

  task automatic test_lock_idle();
    bit r0_t [6]  = '{0, 0, 1, 1, 1, 1};
    bit r1_t [6]  = '{1, 1, 0, 1, 1, 1};
    bit wg0_t [6] = '{0, 0, 0, 0, 0, 1};
    bit wg1_t [6] = '{1, 1, 0, 1, 1, 0};
    do_reset();
    for (int i = 0; i < 6; i++) begin
      drive(r0_t[i], 1, 32'h20, 32'(i), r1_t[i], 1, 1, 32'h24, 32'(i + 100));
      n_tests++; if (m0_if.gnt !== wg0_t[i] || m1_if.gnt !== wg1_t[i]) begin
        n_fail++; $display("FAIL lock_idle[%0d]: got %b%b want %b%b", i, m0_if.gnt,
                           m1_if.gnt, wg0_t[i], wg1_t[i]); end
      tick();
    end
    idle(); tick();
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    drive(0, 0, 0, 0, 1, 1, 0, 32'h80, 0);
    tick();
    n_tests++; if (m1_if.rvalid !== 1'b1 || m1_if.rdata !== exp_mem[32]) begin
      n_fail++; $display("FAIL mid_rv: rvalid=%b rdata=%h want 1 %h", m1_if.rvalid,
                         m1_if.rdata, exp_mem[32]); end
    drive(1, 1, 32'h84, 32'h0BADF00D, 1, 1, 1, 32'h84, 32'h12345678);
    rst_n = 1'b0;
    #1;
    n_tests++; if (m1_if.rvalid !== 1'b0 || m0_if.gnt !== 1'b0 || m1_if.gnt !== 1'b0 ||
                   ram_we !== 1'b0 || ram_addr !== 32'h0) begin
      n_fail++; $display("FAIL mid_rst: rv=%b gnt=%b%b we=%b addr=%h want all 0",
                         m1_if.rvalid, m0_if.gnt, m1_if.gnt, ram_we, ram_addr); end
    model_reset();
    @(posedge clk); #2;
    rst_n = 1'b1;
    n_tests++; if (ram_mem[33] !== exp_mem[33]) begin
      n_fail++; $display("FAIL mid_nowr: got %h want %h", ram_mem[33], exp_mem[33]); end
    drive(1, 0, 32'h84, 0, 1, 0, 0, 32'h84, 0);
    n_tests++; if (m0_if.gnt !== 1'b1 || m1_if.gnt !== 1'b0) begin
      n_fail++; $display("FAIL mid_first: got %b%b want 10", m0_if.gnt, m1_if.gnt); end
    tick();
    idle(); tick();
  endtask

  task automatic test_back_to_back();
    drive(1, 0, 32'h40, 0, 0, 0, 0, 0, 0);
    tick();
    drive(1, 1, 32'h40, 32'h5, 0, 0, 0, 0, 0);
    n_tests++; if (m0_if.rvalid !== 1'b1 || m0_if.rdata !== e_rd0 || m0_if.gnt !== 1'b1) begin
      n_fail++; $display("FAIL b2b_rd: rv=%b rdata=%h gnt=%b want 1 %h 1",
                         m0_if.rvalid, m0_if.rdata, m0_if.gnt, e_rd0); end
    tick();
    idle();
    n_tests++; if (m0_if.rvalid !== 1'b0 || ram_mem[16] !== 32'h5) begin
      n_fail++; $display("FAIL b2b_wr: rv=%b mem=%h want 0 00000005", m0_if.rvalid,
                         ram_mem[16]); end
    tick();
  endtask

  task automatic test_random();
    logic r0, w0, r1, l1, w1;
    logic [31:0] a0, d0, a1, d1;
    bit h0, h1;
    int bad;
    h0 = 0; h1 = 0; bad = 0;
    r0 = 0; w0 = 0; a0 = 0; d0 = 0; r1 = 0; l1 = 0; w1 = 0; a1 = 0; d1 = 0;
    for (int i = 0; i < 400; i++) begin
      if (!h0) begin
        r0 = ($urandom_range(0, 2) != 0); w0 = $urandom_range(0, 1);
        a0 = 32'($urandom_range(0, 255)) << 2; d0 = $urandom;
      end
      if (!h1) begin
        r1 = ($urandom_range(0, 2) != 0); w1 = $urandom_range(0, 1);
        l1 = mdl_locked ? ($urandom_range(0, 5) != 0) : ($urandom_range(0, 3) == 0);
        a1 = 32'($urandom_range(0, 255)) << 2; d1 = $urandom;
      end
      drive(r0, w0, a0, d0, r1, l1, w1, a1, d1);
      if (m0_if.gnt !== e_g0 || m1_if.gnt !== e_g1 || ram_we !== e_we ||
          ram_addr !== e_addr || ram_wdata !== e_wdata) begin
        bad++;
        if (bad < 5) $display("FAIL rnd_bus[%0d]: gnt=%b%b we=%b addr=%h want %b%b %b %h",
                              i, m0_if.gnt, m1_if.gnt, ram_we, ram_addr, e_g0, e_g1, e_we, e_addr);
      end
      if (m0_if.rvalid !== e_rv0 || m1_if.rvalid !== e_rv1 ||
          m0_if.rdata !== e_rd0 || m1_if.rdata !== e_rd1) begin
        bad++;
        if (bad < 5) $display("FAIL rnd_rd[%0d]: rv=%b%b rd=%h/%h want %b%b %h/%h", i,
                              m0_if.rvalid, m1_if.rvalid, m0_if.rdata, m1_if.rdata,
                              e_rv0, e_rv1, e_rd0, e_rd1);
      end
      h0 = r0 && !e_g0;
      h1 = r1 && !e_g1 && !mdl_locked;
      tick();
    end
    n_tests++; if (bad != 0) begin
      n_fail++; $display("FAIL rnd_total: %0d bad cycles want 0", bad); end
    idle(); tick();
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin ram_mem[i] = 32'(i * 3); exp_mem[i] = 32'(i * 3); end
    rst_n = 1'b0;
    model_reset();
    idle();
    #20;
    test_reset();
    test_write_read();
    test_round_robin();
    test_lock_burst();
    test_lock_idle();
    test_reset_mid_burst();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
